// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: state encoding and
// the parameter sets used in the product and in the small test configuration.
package modexp_pkg;

    localparam int unsigned DefWid     = 256;
    localparam int unsigned DefEwid    = 256;
    localparam int unsigned DefCntwid  = 8;

    localparam int unsigned TestWid    = 4;
    localparam int unsigned TestEwid   = 4;
    localparam int unsigned TestCntwid = 2;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StToMont   = 3'd1,
        StSqr      = 3'd2,
        StMul      = 3'd3,
        StFromMont = 3'd4
    } state_e;

endpackage

// File: rtl/modexp_ctrl.sv
// Constant-time left-to-right square-and-multiply sequencer driving an external
// Montgomery multiplier through a start/vld handshake.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int unsigned WID    = DefWid,
    parameter int unsigned EWID   = DefEwid,
    parameter int unsigned CNTWID = DefCntwid
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WID-1:0]  x,
    input  logic [EWID-1:0] e,
    input  logic [WID-1:0]  m,
    input  logic [WID-1:0]  rm,
    input  logic [WID-1:0]  r2,
    output logic            busy,
    output logic            vld,
    output logic [WID-1:0]  r,
    output logic [WID-1:0]  mm_a,
    output logic [WID-1:0]  mm_b,
    output logic [WID-1:0]  mm_m,
    output logic            mm_start,
    input  logic [WID-1:0]  mm_r,
    input  logic            mm_vld
);

    localparam logic [CNTWID-1:0] IdxTop = CNTWID'(EWID - 1);

    state_e            state_q, state_d;
    logic [WID-1:0]    x_q, x_d;
    logic [EWID-1:0]   e_q, e_d;
    logic [WID-1:0]    m_q, m_d;
    logic [WID-1:0]    r2_q, r2_d;
    logic [WID-1:0]    xm_q, xm_d;
    logic [WID-1:0]    acc_q, acc_d;
    logic [CNTWID-1:0] idx_q, idx_d;
    logic [WID-1:0]    r_q, r_d;
    logic              vld_q, vld_d;
    logic              mm_start_q, mm_start_d;
    logic              op_done;

    // A done pulse coinciding with the request cycle belongs to no issued product.
    assign op_done = mm_vld && !mm_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            r2_q       <= '0;
            xm_q       <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            r_q        <= '0;
            vld_q      <= 1'b0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            e_q        <= e_d;
            m_q        <= m_d;
            r2_q       <= r2_d;
            xm_q       <= xm_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            r_q        <= r_d;
            vld_q      <= vld_d;
            mm_start_q <= mm_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        e_d        = e_q;
        m_d        = m_q;
        r2_d       = r2_q;
        xm_d       = xm_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        r_d        = r_q;
        vld_d      = 1'b0;
        mm_start_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d        = x;
                    e_d        = e;
                    m_d        = m;
                    r2_d       = r2;
                    acc_d      = rm;
                    idx_d      = IdxTop;
                    state_d    = StToMont;
                    mm_start_d = 1'b1;
                end
            end
            StToMont: begin
                if (op_done) begin
                    xm_d       = mm_r;
                    state_d    = StSqr;
                    mm_start_d = 1'b1;
                end
            end
            StSqr: begin
                if (op_done) begin
                    acc_d      = mm_r;
                    state_d    = StMul;
                    mm_start_d = 1'b1;
                end
            end
            StMul: begin
                // The multiply always runs; only the write-back depends on the key bit.
                if (op_done) begin
                    if (e_q[idx_q]) begin
                        acc_d = mm_r;
                    end
                    if (idx_q == '0) begin
                        state_d = StFromMont;
                    end else begin
                        idx_d   = idx_q - CNTWID'(1);
                        state_d = StSqr;
                    end
                    mm_start_d = 1'b1;
                end
            end
            StFromMont: begin
                if (op_done) begin
                    r_d     = mm_r;
                    vld_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            StToMont: begin
                mm_a = x_q;
                mm_b = r2_q;
            end
            StSqr: begin
                mm_a = acc_q;
                mm_b = acc_q;
            end
            StMul: begin
                mm_a = acc_q;
                mm_b = xm_q;
            end
            StFromMont: begin
                mm_a = acc_q;
                mm_b = WID'(1);
            end
            default: begin
                mm_a = '0;
                mm_b = '0;
            end
        endcase
    end

    assign mm_m     = m_q;
    assign mm_start = mm_start_q;
    assign busy     = (state_q != StIdle);
    assign vld      = vld_q;
    assign r        = r_q;

endmodule
